// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU output port transmitter.
// OUTPUT_PORT_PARITY_EN selects the 11-bit (even parity) frame length.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;

`ifdef OUTPUT_PORT_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the wrap.
// Held at 0 while clear is high so each frame starts on a full bit period.
module baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count and wrap tick.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/output_port_tx.sv
// CPU output port transmitter: one-entry holding register feeding a UART 8N1
// serialiser (LSB first, registered tx, idle high).
// Defining OUTPUT_PORT_PARITY_EN inserts an even-parity bit before the stop bit.
module output_port_tx
    import cpu_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              busy,
    output logic              tx
);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              hold_full_q, hold_full_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              bit_tick;
    logic              baud_clear;
    logic              start_frame;
`ifdef OUTPUT_PORT_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // Timer idles at 0 so the start bit always gets a full period.
    assign baud_clear = (state_q == IDLE);

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (bit_tick)
    );

    // Next-state logic: holding-register accept, FSM and shifter.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        start_frame = 1'b0;
`ifdef OUTPUT_PORT_PARITY_EN
        parity_d    = parity_q;
`endif

        // A load while full is dropped silently.
        if (load && !hold_full_q) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef OUTPUT_PORT_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef OUTPUT_PORT_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    // Queued byte goes straight into the next start bit.
                    if (hold_full_q) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Transfer holding -> shift; load cannot coincide since ready was 0.
        if (start_frame) begin
            state_d     = START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
`ifdef OUTPUT_PORT_PARITY_EN
            parity_d    = ^hold_q;
`endif
        end
    end

    // State registers; async reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            shift_q     <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            tx_q        <= 1'b1;
`ifdef OUTPUT_PORT_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
`ifdef OUTPUT_PORT_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign tx    = tx_q;
    assign ready = !hold_full_q;
    assign busy  = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_output_port_tx.sv
// Directed bench for output_port_tx with CLKS_PER_BIT = 4.
// Parity scenarios are included when OUTPUT_PORT_PARITY_EN is defined.
module tb_output_port_tx;
    import cpu_pkg::*;

    localparam int unsigned CPB = 4;
    localparam int NS = int'(FRAME_BITS * CPB);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, busy, tx;

    int errors = 0;
    int checks = 0;
    logic cap [0:199];

    always #5 clk = ~clk;

    output_port_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data_in(data_in),
        .load   (load),
        .ready  (ready),
        .busy   (busy),
        .tx     (tx)
    );

    // Expected per-cycle tx waveform of one frame for byte d.
    function automatic logic [43:0] wave(input logic [7:0] d);
        logic [10:0] f;
        logic [43:0] w;
`ifdef OUTPUT_PORT_PARITY_EN
        f = {1'b1, ^d, d, 1'b0};
`else
        f = {1'b0, 1'b1, d, 1'b0};
`endif
        w = '0;
        for (int i = 0; i < NS; i++) w[i] = f[i / CPB];
        return w;
    endfunction

    function automatic logic [43:0] idle_wave();
        logic [43:0] w;
        w = '0;
        for (int i = 0; i < NS; i++) w[i] = 1'b1;
        return w;
    endfunction

    function automatic logic [43:0] win(input int off);
        logic [43:0] w;
        w = '0;
        for (int i = 0; i < NS; i++) w[i] = cap[off + i];
        return w;
    endfunction

    task automatic capture(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap[first + i] = tx;
        end
    endtask

    // Drive load for one edge; returns #1 after that edge.
    task automatic pulse_load(input logic [7:0] d);
        @(negedge clk);
        data_in = d;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_byte;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_pre: got %b expected 1", ready); end
        pulse_load(8'hA5);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL single_ready_e0: got %b expected 0", ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_e0: got %b expected 1", busy); end
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_e0: got %b expected 1", tx); end
        @(posedge clk);
        #1;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start_e1: got %b expected 0", tx); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready_e1: got %b expected 1", ready); end
        capture(0, NS);
        checks++; if (win(0) !== wave(8'hA5)) begin errors++; $display("FAIL single_frame: got %h expected %h", win(0), wave(8'hA5)); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last: got %b expected 1", busy); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_end: got %b expected 1", tx); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        pulse_load(8'h01);
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_e1: got %b expected 1", ready); end
        data_in = 8'hFF;
        load = 1'b1;
        @(negedge clk);
        cap[0] = tx;
        @(posedge clk);
        #1;
        load = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_queued: got %b expected 0", ready); end
        capture(1, 2 * NS - 1);
        checks++; if (win(0) !== wave(8'h01)) begin errors++; $display("FAIL b2b_frame1: got %h expected %h", win(0), wave(8'h01)); end
        checks++; if (win(NS) !== wave(8'hFF)) begin errors++; $display("FAIL b2b_frame2: got %h expected %h", win(NS), wave(8'hFF)); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overrun;
        pulse_load(8'h11);
        @(posedge clk);
        #1;
        data_in = 8'h22;
        load = 1'b1;
        @(negedge clk);
        cap[0] = tx;
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL overrun_ready: got %b expected 0", ready); end
        data_in = 8'h33;
        @(negedge clk);
        cap[1] = tx;
        @(posedge clk);
        #1;
        load = 1'b0;
        capture(2, 3 * NS - 2);
        checks++; if (win(0) !== wave(8'h11)) begin errors++; $display("FAIL overrun_frame1: got %h expected %h", win(0), wave(8'h11)); end
        checks++; if (win(NS) !== wave(8'h22)) begin errors++; $display("FAIL overrun_frame2: got %h expected %h", win(NS), wave(8'h22)); end
        checks++; if (win(2 * NS) !== idle_wave()) begin errors++; $display("FAIL overrun_dropped: got %h expected %h", win(2 * NS), idle_wave()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overrun_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_frame;
        pulse_load(8'hA5);
        repeat (11) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        capture(0, 2 * NS);
        checks++; if (win(0) !== idle_wave()) begin errors++; $display("FAIL rstmid_quiet1: got %h expected %h", win(0), idle_wave()); end
        checks++; if (win(NS) !== idle_wave()) begin errors++; $display("FAIL rstmid_quiet2: got %h expected %h", win(NS), idle_wave()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_reset_queued;
        pulse_load(8'h11);
        @(posedge clk);
        #1;
        data_in = 8'h22;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstq_full: got %b expected 0", ready); end
        rst = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstq_ready: got %b expected 1", ready); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstq_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstq_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        capture(0, 2 * NS);
        checks++; if (win(0) !== idle_wave()) begin errors++; $display("FAIL rstq_quiet1: got %h expected %h", win(0), idle_wave()); end
        checks++; if (win(NS) !== idle_wave()) begin errors++; $display("FAIL rstq_quiet2: got %h expected %h", win(NS), idle_wave()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstq_busy_after: got %b expected 0", busy); end
    endtask

`ifdef OUTPUT_PORT_PARITY_EN
    task automatic test_parity;
        pulse_load(8'h07);
        @(posedge clk);
        #1;
        capture(0, NS);
        checks++; if (cap[38] !== 1'b1) begin errors++; $display("FAIL parity_07_bit: got %b expected 1", cap[38]); end
        checks++; if (win(0) !== wave(8'h07)) begin errors++; $display("FAIL parity_07_frame: got %h expected %h", win(0), wave(8'h07)); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL parity_busy_44: got %b expected 1", busy); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL parity_busy_end: got %b expected 0", busy); end
        pulse_load(8'h03);
        @(posedge clk);
        #1;
        capture(0, NS);
        checks++; if (cap[38] !== 1'b0) begin errors++; $display("FAIL parity_03_bit: got %b expected 0", cap[38]); end
        checks++; if (win(0) !== wave(8'h03)) begin errors++; $display("FAIL parity_03_frame: got %h expected %h", win(0), wave(8'h03)); end
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        test_reset_queued();
`ifdef OUTPUT_PORT_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_port_tx.md
# output_port_tx

CPU output port transmitter: the sending end of the 8-bit data path into which bus registers are loaded. On a `load` strobe it captures an 8-bit value from the CPU bus into a one-entry holding register. It then serialises the value as a UART 8N1 frame on `tx`, LSB first. It sits between the CPU's output-register load control and the board's serial pin, so the CPU can emit bytes without stalling on the bit rate.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `data_in`  in  8  byte from the CPU bus.
- `load`  in  1  active high; write request for `data_in`.
- `ready`  out  1  high when the holding register is empty; a `load` is accepted only in a cycle where `ready` = 1.
- `busy`  out  1  high while a frame is in flight or the holding register is full.
- `tx`  out  1  serial line, registered, idle high.

## Operation
- **Reset values:** `tx` = 1, `ready` = 1, `busy` = 0, FSM in IDLE, holding register cleared to 0x00, counters 0. Reset asserted mid-frame aborts the frame immediately, because the reset is asynchronous.
- **Accept:**
  - At a rising edge where `load` = 1 and `ready` = 1, `data_in` is copied to the holding register and holding_full is set.
  - A `load` while `ready` = 0 is ignored (the byte is dropped, with no error flag).
- **FSM states:** IDLE, START, DATA, [PARITY], STOP.
  - IDLE → START when holding_full = 1. On that same edge the holding register moves into the shift register, holding_full clears, and `tx` goes to 0.
  - START → DATA after `CLKS_PER_BIT` cycles. `tx` = shift[0].
  - DATA: shifts right every `CLKS_PER_BIT` cycles. A 3-bit bit counter runs 0 to 7; after bit 7 the FSM goes to STOP (or to PARITY, see Configuration).
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles. At the end it goes to START if holding_full = 1 (back-to-back, no idle gap), otherwise to IDLE.
- **Baud counter:**
  - Width `$clog2(CLKS_PER_BIT)`. It counts 0 to `CLKS_PER_BIT`-1, wraps to 0, and produces a one-cycle bit_tick on the wrap.
  - It is held at 0 in IDLE, and restarts at 0 on each IDLE→START transition.
- **Simultaneous events:** if a transfer from holding to shift happens on the same edge as a `load`, the `load` is ignored, because `ready` was 0 in that cycle. `ready` rises on the following cycle.
- **`busy`** = (state ≠ IDLE) OR holding_full.

## Timing
- Let E0 be the edge at which `load` is sampled with `ready` = 1.
  - Just after E0: `ready` = 0.
  - At E1 (if IDLE): `tx` falls, `ready` returns to 1.
- **Frame length:** 10 × `CLKS_PER_BIT` cycles (11 × with parity), measured from the `tx` falling edge to the end of the stop bit.
- **Back-to-back:** the next start bit begins on the edge immediately after the last stop-bit cycle.
- **Throughput:** one byte per frame. The CPU can queue one byte while the previous byte is being shifted out.

## Configuration
- **`OUTPUT_PORT_PARITY_EN` defined:**
  - Adds the PARITY state between DATA and STOP.
  - `tx` = even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Frame = 11 bits.
- **`OUTPUT_PORT_PARITY_EN` undefined:** no PARITY state and no parity logic; frame = 10 bits.

## Structure
- **Shared package `cpu_pkg`:**
  - FSM state typedef `tx_state_t`: IDLE, START, DATA, PARITY, STOP.
  - `DATA_W` = 8.
  - `FRAME_BITS` = 10 / 11, selected by `OUTPUT_PORT_PARITY_EN`.
- **Sub-module `baud_gen`:**
  - Parameterised by `CLKS_PER_BIT`.
  - Inputs: `clk`, `rst`, `clear`.
  - Output: `tick`.
  - Instantiated once.
- Holding register, shift register, bit counter and FSM are in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4.
- **Reset:** pulse `rst` low mid-frame → `tx` = 1, `ready` = 1, `busy` = 0 asynchronously. There is no further `tx` activity until a new `load`.
- **Single byte:**
  - Stimulus: `load` 0xA5 from IDLE.
  - Required `tx` sequence: 0, 1,0,1,0,0,1,0,1, 1, each level for 4 cycles.
  - The start bit begins 1 cycle after the accept edge, and `busy` falls after 40 cycles.
- **Back-to-back:**
  - Stimulus: `load` 0x01, then `load` 0xFF as soon as `ready` = 1.
  - Required: two contiguous 40-cycle frames with no idle cycle between them.
- **Overrun:**
  - Stimulus: `load` 0x11, 0x22, and 0x33 while `ready` = 0.
  - Required: only 0x11 and 0x22 are transmitted; 0x33 is dropped.
- **Parity build (`OUTPUT_PORT_PARITY_EN` defined):**
  - `load` 0x07 → parity bit = 1, frame = 44 cycles.
  - `load` 0x03 → parity bit = 0.
- **Reset during a queued byte:**
  - Stimulus: holding full (second byte queued) when `rst` is asserted.
  - Required: after reset release, `tx` stays 1 and the queued byte is never sent.
